// File: rtl/prim_accum.sv
// prim_accum: signed-combining accumulator for inclusion-exclusion partial sums, with a one-deep
// result hold stage and running totals. Optional overflow checking via `PRIM_ACCUM_OVF_CHECK_EN.

`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

module prim_accum (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`LONG_DATA_WIDTH-1:0] in_data,
  input  logic                        in_sign,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [`LONG_DATA_WIDTH-1:0] out_range_sum,
  output logic [`LONG_DATA_WIDTH-1:0] total_sum,
  output logic [15:0]                 range_count,
  input  logic                        clear_totals,
  output logic                        ovf_err
);

  localparam int W = `LONG_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_base;
  logic [W-1:0]   acc_upd;
  logic [W-1:0]   total_base;
  logic [W-1:0]   total_upd;
  logic [15:0]    count_base;
  logic [15:0]    count_upd;
  logic           accept;
  logic           handoff;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;

  // A range always starts from zero, independent of whatever acc happens to hold in IDLE.
  assign acc_base = (state == IDLE) ? '0 : acc;
  assign acc_upd  = in_sign ? (acc_base - in_data) : (acc_base + in_data);

  // Clear wins first, then a coincident handoff adds on top of the cleared totals.
  always_comb begin
    total_base = clear_totals ? '0 : total_sum;
    count_base = clear_totals ? '0 : range_count;
    total_upd  = total_base;
    count_upd  = count_base;
    if (handoff) begin
      total_upd = total_base + out_range_sum;
      count_upd = count_base + 16'd1;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (accept) state_next = in_last ? HOLD : ACCUM;
      end
      HOLD: begin
        if (handoff) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      out_range_sum <= '0;
      total_sum     <= '0;
      range_count   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (in_last) begin
          out_range_sum <= acc_upd;
          acc           <= '0;
        end else begin
          acc <= acc_upd;
        end
      end
      if (clear_totals || handoff) begin
        total_sum   <= total_upd;
        range_count <= count_upd;
      end
    end
  end

`ifdef PRIM_ACCUM_OVF_CHECK_EN
  logic         total_carry;
  logic [W-1:0] total_sum_unused;
  logic         ovf_q;

  // Carry is taken from the same base the register update uses, so a coincident clear is honoured.
  assign {total_carry, total_sum_unused} = {1'b0, total_base} + {1'b0, out_range_sum};

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if ((accept && in_last && acc_upd[W-1]) || (handoff && total_carry)) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_prim_accum.sv
// Self-checking bench for prim_accum: directed scenarios plus randomized traffic checked against a
// transaction-level model (pending result, running acc, totals).

`timescale 1ns/1ps

`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

module tb_prim_accum;

  localparam int W = `LONG_DATA_WIDTH;
`ifdef PRIM_ACCUM_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_sign;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_range_sum;
  logic [W-1:0] total_sum;
  logic [15:0]  range_count;
  logic         clear_totals;
  logic         ovf_err;

  int vectors;
  int miscompares;

  // Reference model state: one pending result slot and a running range sum.
  bit           m_pending;
  logic [W-1:0] m_acc;
  logic [W-1:0] m_result;
  logic [W-1:0] m_total;
  logic [15:0]  m_count;
  bit           m_ovf;

  prim_accum dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sign      (in_sign),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_range_sum(out_range_sum),
    .total_sum    (total_sum),
    .range_count  (range_count),
    .clear_totals (clear_totals),
    .ovf_err      (ovf_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_edge();
    logic [W:0]   wide;
    logic [W-1:0] base;
    logic [W-1:0] term;
    bit           take;
    bit           give;
    if (reset) begin
      m_pending = 0; m_acc = '0; m_result = '0; m_total = '0; m_count = '0; m_ovf = 0;
      return;
    end
    take = in_valid && !m_pending;
    give = m_pending && out_ready;
    base = clear_totals ? '0 : m_total;
    if (clear_totals) m_count = '0;
    m_total = base;
    if (give) begin
      wide = {1'b0, base} + {1'b0, m_result};
      m_total = wide[W-1:0];
      m_count = m_count + 16'd1;
      if (wide[W]) m_ovf = 1;
      m_pending = 0;
    end
    if (take) begin
      term = in_sign ? (m_acc - in_data) : (m_acc + in_data);
      if (in_last) begin
        m_result  = term;
        m_pending = 1;
        m_acc     = '0;
        if (term[W-1]) m_ovf = 1;
      end else begin
        m_acc = term;
      end
    end
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit s, input bit l,
                       input bit ordy, input bit clr);
    in_valid = v; in_data = d; in_sign = s; in_last = l; out_ready = ordy; clear_totals = clr;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, W'(77), 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_range_sum !== '0 || total_sum !== '0 ||
        range_count !== 16'd0 || ovf_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ov=%b ir=%b sum=%0d tot=%0d cnt=%0d ovf=%b, want 0 1 0 0 0 0",
               out_valid, in_ready, out_range_sum, total_sum, range_count, ovf_err);
    end
  endtask

  task automatic test_two_terms();
    drive(1'b1, W'(33), 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL two_terms_mid: ov=%b ir=%b, want 0 1", out_valid, in_ready);
    end
    drive(1'b1, W'(3333), 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_range_sum !== W'(3366)) begin
      miscompares++;
      $display("FAIL two_terms_result: ov=%b sum=%0d, want 1 3366", out_valid, out_range_sum);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (total_sum !== W'(3366) || range_count !== 16'd1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL two_terms_totals: tot=%0d cnt=%0d ov=%b, want 3366 1 0",
               total_sum, range_count, out_valid);
    end
  endtask

  task automatic test_mixed_sign();
    drive(1'b1, W'(5050), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, W'(495),  1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, W'(55),   1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_range_sum !== W'(5490)) begin
      miscompares++;
      $display("FAIL mixed_sign: ov=%b sum=%0d, want 1 5490", out_valid, out_range_sum);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    vectors++;
    if (total_sum !== W'(3366 + 5490) || range_count !== 16'd2) begin
      miscompares++;
      $display("FAIL mixed_totals: tot=%0d cnt=%0d, want 8856 2", total_sum, range_count);
    end
  endtask

  task automatic test_back_pressure();
    drive(1'b1, W'(9), 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, W'(1000), 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_range_sum !== W'(9)) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: ir=%b ov=%b sum=%0d, want 0 1 9",
                 i, in_ready, out_valid, out_range_sum);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || range_count !== 16'd3) begin
      miscompares++;
      $display("FAIL hold_handoff: ir=%b ov=%b cnt=%0d, want 1 0 3", in_ready, out_valid, range_count);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_range_sum !== W'(1000)) begin
      miscompares++;
      $display("FAIL hold_next_term: ov=%b sum=%0d, want 1 1000", out_valid, out_range_sum);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_clear_coincident();
    drive(1'b1, W'(100), 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);      tick();
    drive(1'b1, W'(250), 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);      tick();
    vectors++;
    if (total_sum !== m_total || range_count !== m_count) begin
      miscompares++;
      $display("FAIL clear_pre: tot=%0d cnt=%0d, want %0d %0d", total_sum, range_count, m_total, m_count);
    end
    drive(1'b1, W'(7), 1'b0, 1'b1, 1'b0, 1'b0);   tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);      tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (total_sum !== W'(7) || range_count !== 16'd1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_with_handoff: tot=%0d cnt=%0d ov=%b, want 7 1 0",
               total_sum, range_count, out_valid);
    end
  endtask

  task automatic test_reset_mid_range();
    drive(1'b1, W'(10), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, W'(20), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    reset = 1'b1;
    drive(1'b1, W'(5), 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || total_sum !== '0 || range_count !== 16'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: ov=%b tot=%0d cnt=%0d ir=%b, want 0 0 0 1",
               out_valid, total_sum, range_count, in_ready);
    end
    drive(1'b1, W'(4), 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_range_sum !== W'(4)) begin
      miscompares++;
      $display("FAIL reset_then_single: ov=%b sum=%0d, want 1 4", out_valid, out_range_sum);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_negative_result();
    logic [W-1:0] ones;
    ones = '1;
    drive(1'b1, W'(1), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, W'(2), 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_range_sum !== ones || ovf_err !== OVF_EN) begin
        miscompares++;
        $display("FAIL negative_result[%0d]: sum=%h ovf=%b, want %h %b", i, out_range_sum, ovf_err, ones, OVF_EN);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    vectors++;
    if (ovf_err !== OVF_EN || total_sum !== W'(3)) begin
      miscompares++;
      $display("FAIL negative_sticky: ovf=%b tot=%0d, want %b 3", ovf_err, total_sum, OVF_EN);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic [W-1:0] exp_ovf;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      d = ($urandom_range(0, 3) == 0) ? W'({$urandom, $urandom}) : W'($urandom_range(0, 5000));
      drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
      tick();
      exp_ovf = W'(OVF_EN && m_ovf);
      vectors++;
      if (in_ready !== !m_pending || out_valid !== m_pending ||
          (m_pending && out_range_sum !== m_result) || total_sum !== m_total ||
          range_count !== m_count || ovf_err !== exp_ovf[0]) begin
        miscompares++;
        $display("FAIL random[%0d]: ir=%b ov=%b sum=%0d tot=%0d cnt=%0d ovf=%b, want %b %b %0d %0d %0d %b",
                 i, in_ready, out_valid, out_range_sum, total_sum, range_count, ovf_err,
                 !m_pending, m_pending, m_result, m_total, m_count, exp_ovf[0]);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_two_terms();
    test_mixed_sign();
    test_back_pressure();
    test_clear_coincident();
    test_reset_mid_range();
    test_negative_result();
    reset = 1'b1; tick(); reset = 1'b0;
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
